// File: rtl/risc_pkg.sv
// Shared ISA and controller types for the 8-bit RISC datapath: opcodes,
// sequencer states and the strobe bundle the controller decodes.
package risc_pkg;

  localparam int OPW_ISA = 3;

  typedef enum logic [OPW_ISA-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  // Nine states need four bits; the seven spare codes are treated as illegal.
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } ctrl_state_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic ld_pc;
    logic inc_pc;
    logic data_e;
    logic halt;
  } ctrl_out_t;

  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Controller <-> datapath strobe interface. The step input exists only when
// CTRL_SINGLE_STEP_EN is defined.
interface risc_controller_if #(
  parameter int OPW = 3
);
  logic [OPW-1:0] opcode;
  logic           zero;
`ifdef CTRL_SINGLE_STEP_EN
  logic           step;
`endif
  logic           sel;
  logic           rd;
  logic           wr;
  logic           ld_ir;
  logic           ld_ac;
  logic           ld_pc;
  logic           inc_pc;
  logic           data_e;
  logic           halt;

  modport master (
`ifdef CTRL_SINGLE_STEP_EN
    input  step,
`endif
    input  opcode, zero,
    output sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt
  );

  modport slave (
`ifdef CTRL_SINGLE_STEP_EN
    output step,
`endif
    output opcode, zero,
    input  sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt
  );
endinterface

// File: rtl/risc_controller.sv
// Eight-phase fetch/execute sequencer driving all datapath strobes.
// Optional CTRL_SINGLE_STEP_EN: hold in INST_ADDR until step is sampled high.
module risc_controller
  import risc_pkg::*;
#(
  parameter int OPW = OPW_ISA
) (
  input  logic               clk,
  input  logic               rst,
  risc_controller_if.master  bus
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;
  ctrl_out_t   w_out;
  opcode_t     w_op;
  logic        w_alu;

  assign w_op  = opcode_t'(bus.opcode[OPW-1:0]);
  assign w_alu = is_aluop(w_op);

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) r_state <= INST_ADDR;
    else     r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next = INST_ADDR;
    case (r_state)
`ifdef CTRL_SINGLE_STEP_EN
      INST_ADDR:  w_next = bus.step ? INST_FETCH : INST_ADDR;
`else
      INST_ADDR:  w_next = INST_FETCH;
`endif
      INST_FETCH: w_next = INST_LOAD;
      INST_LOAD:  w_next = IDLE;
      IDLE:       w_next = OP_ADDR;
      OP_ADDR:    w_next = (w_op == HLT) ? HALTED : OP_FETCH;
      OP_FETCH:   w_next = ALU_OP;
      ALU_OP:     w_next = STORE;
      STORE:      w_next = INST_ADDR;
      HALTED:     w_next = HALTED;
      default:    w_next = INST_ADDR;
    endcase
  end

  always_comb begin
    w_out = '0;
    case (r_state)
      INST_ADDR: w_out.sel = 1'b1;
      INST_FETCH: begin
        w_out.sel = 1'b1;
        w_out.rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        w_out.sel   = 1'b1;
        w_out.rd    = 1'b1;
        w_out.ld_ir = 1'b1;
      end
      OP_ADDR:  w_out.inc_pc = 1'b1;
      OP_FETCH: w_out.rd     = w_alu;
      // The accumulator loads on both ALU_OP and STORE edges with stable data.
      ALU_OP: begin
        w_out.rd     = w_alu;
        w_out.ld_ac  = w_alu;
        w_out.inc_pc = (w_op == SKZ) && bus.zero;
        w_out.ld_pc  = (w_op == JMP);
        w_out.data_e = (w_op == STO);
      end
      STORE: begin
        w_out.rd     = w_alu;
        w_out.ld_ac  = w_alu;
        w_out.ld_pc  = (w_op == JMP);
        w_out.inc_pc = (w_op == JMP);
        w_out.wr     = (w_op == STO);
        w_out.data_e = (w_op == STO);
      end
      HALTED:  w_out.halt = 1'b1;
      default: w_out = '0;
    endcase
  end

  assign bus.sel    = w_out.sel;
  assign bus.rd     = w_out.rd;
  assign bus.wr     = w_out.wr;
  assign bus.ld_ir  = w_out.ld_ir;
  assign bus.ld_ac  = w_out.ld_ac;
  assign bus.ld_pc  = w_out.ld_pc;
  assign bus.inc_pc = w_out.inc_pc;
  assign bus.data_e = w_out.data_e;
  assign bus.halt   = w_out.halt;

endmodule

// File: tb/tb_risc_controller.sv
// Self-checking bench for risc_controller: per-instruction strobe tables,
// hand-written halt/reset/step sequences and a randomized run against a model.
module tb_risc_controller;
  import risc_pkg::*;

`ifdef CTRL_SINGLE_STEP_EN
  localparam bit SS_EN = 1'b1;
`else
  localparam bit SS_EN = 1'b0;
`endif

  // Cycle masks: bit k is cycle k+1 of an instruction.
  localparam logic [7:0] SEL_M  = 8'h0F;
  localparam logic [7:0] LDIR_M = 8'h0C;
  localparam logic [8:0] RESET_OUT = 9'b0_1000_0000;
  localparam logic [8:0] HALT_OUT  = 9'b1_0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  risc_controller_if #(.OPW(3)) bus ();
  risc_controller #(.OPW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  // {halt, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e}
  logic [8:0] obs;
  assign obs = {bus.halt, bus.sel, bus.rd, bus.wr, bus.ld_ir,
                bus.ld_ac, bus.ld_pc, bus.inc_pc, bus.data_e};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycle position within the instruction plus a halted flag.
  int m_phase;
  bit m_halted;

  typedef struct {
    string      name;
    opcode_t    op;
    logic       z;
    logic [7:0] rd_m, wr_m, ld_ac_m, ld_pc_m, inc_m, de_m;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (halt,sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e)",
               name, act, exp);
    end
  endtask

  function automatic logic [8:0] model_out(int ph, bit hl, opcode_t op, logic z);
    logic alu, late;
    if (hl) return HALT_OUT;
    alu  = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    late = (ph >= 6);
    return {1'b0,
            logic'(ph <= 3),
            logic'((ph >= 1 && ph <= 3) || (ph >= 5 && alu)),
            logic'(ph == 7 && op == STO),
            logic'(ph == 2 || ph == 3),
            logic'(late && alu),
            logic'(late && op == JMP),
            logic'(ph == 4 || (ph == 6 && op == SKZ && z) || (ph == 7 && op == JMP)),
            logic'(late && op == STO)};
  endfunction

  task automatic model_edge(input opcode_t op, input logic stp, input logic r);
    if (r) begin
      m_phase  = 0;
      m_halted = 1'b0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_phase == 0 && SS_EN && !stp) begin
      m_phase = 0;
    end else if (m_phase == 4 && op == HLT) begin
      m_halted = 1'b1;
    end else begin
      m_phase = (m_phase + 1) % 8;
    end
  endtask

  task automatic drive(input opcode_t op, input logic z, input logic stp, input logic r);
    bus.opcode = op;
    bus.zero   = z;
`ifdef CTRL_SINGLE_STEP_EN
    bus.step   = stp;
`endif
    rst        = r;
  endtask

  // Entered 1 time unit after a rising edge; leaves 1 time unit after the next.
  task automatic tick(input opcode_t op, input logic z, input logic stp, input logic r,
                      input string name);
    drive(op, z, stp, r);
    #1;
    check(name, obs, model_out(m_phase, m_halted, op, z));
    @(posedge clk);
    #1;
    model_edge(op, stp, r);
  endtask

  initial begin
    opcode_t cur_op;
    int      halt_wait;

    vecs[0] = '{"LDA",     LDA, 1'b0, 8'hEE, 8'h00, 8'hC0, 8'h00, 8'h10, 8'h00};
    vecs[1] = '{"ADD",     ADD, 1'b1, 8'hEE, 8'h00, 8'hC0, 8'h00, 8'h10, 8'h00};
    vecs[2] = '{"AND",     AND, 1'b0, 8'hEE, 8'h00, 8'hC0, 8'h00, 8'h10, 8'h00};
    vecs[3] = '{"XOR",     XOR, 1'b1, 8'hEE, 8'h00, 8'hC0, 8'h00, 8'h10, 8'h00};
    vecs[4] = '{"STO",     STO, 1'b1, 8'h0E, 8'h80, 8'h00, 8'h00, 8'h10, 8'hC0};
    vecs[5] = '{"SKZ_z1",  SKZ, 1'b1, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h50, 8'h00};
    vecs[6] = '{"SKZ_z0",  SKZ, 1'b0, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00};
    vecs[7] = '{"JMP",     JMP, 1'b0, 8'h0E, 8'h00, 8'h00, 8'hC0, 8'h90, 8'h00};

    // Reset held for two edges; outputs checked during the second.
    drive(HLT, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    m_phase  = 0;
    m_halted = 1'b0;
    drive(HLT, 1'b0, 1'b0, 1'b1);
    #1;
    check("reset_hold", obs, RESET_OUT);
    @(posedge clk);
    #1;
    model_edge(HLT, 1'b0, 1'b1);
    drive(HLT, 1'b0, 1'b1, 1'b0);
    #1;
    check("reset_release", obs, RESET_OUT);

    // Table-driven: one full instruction per entry, checked every cycle.
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < 8; c++) begin
        opcode_t op;
        logic    z;
        op = (c < 3) ? opcode_t'($urandom_range(0, 7)) : vecs[v].op;
        z  = (c == 6) ? vecs[v].z : logic'($urandom_range(0, 1));
        drive(op, z, 1'b1, 1'b0);
        #1;
        check($sformatf("%s_c%0d", vecs[v].name, c + 1), obs,
              {1'b0, SEL_M[c], vecs[v].rd_m[c], vecs[v].wr_m[c], LDIR_M[c],
               vecs[v].ld_ac_m[c], vecs[v].ld_pc_m[c], vecs[v].inc_m[c], vecs[v].de_m[c]});
        @(posedge clk);
        #1;
        model_edge(op, 1'b1, 1'b0);
      end
    end

    // HLT: halted for 20 cycles, only reset leaves it.
    for (int c = 0; c < 5; c++) tick(HLT, 1'b0, 1'b1, 1'b0, "hlt_pre");
    for (int c = 0; c < 20; c++) begin
      drive(opcode_t'($urandom_range(0, 7)), logic'($urandom_range(0, 1)), 1'b1, 1'b0);
      #1;
      check("halted", obs, HALT_OUT);
      @(posedge clk);
      #1;
    end
    tick(HLT, 1'b0, 1'b1, 1'b1, "halted_rst");
    drive(HLT, 1'b0, 1'b1, 1'b0);
    #1;
    check("after_halt_rst", obs, RESET_OUT);

    // Reset asserted during STORE: wr still visible, then INST_ADDR.
    for (int c = 0; c < 7; c++) tick(STO, 1'b0, 1'b1, 1'b0, "sto_pre");
    drive(STO, 1'b0, 1'b1, 1'b1);
    #1;
    check("sto_rst_wr", obs, 9'b0_0010_0001);
    @(posedge clk);
    #1;
    model_edge(STO, 1'b1, 1'b1);
    tick(STO, 1'b0, 1'b1, 1'b0, "sto_rst_after");

`ifdef CTRL_SINGLE_STEP_EN
    // Return to INST_ADDR, then hold with step low and issue a single pulse.
    while (m_phase != 0) tick(ADD, 1'b0, 1'b1, 1'b0, "ss_align");
    for (int c = 0; c < 10; c++) tick(ADD, 1'b0, 1'b0, 1'b0, "ss_hold");
    tick(ADD, 1'b0, 1'b1, 1'b0, "ss_pulse");
    for (int c = 0; c < 7; c++) tick(ADD, 1'b0, 1'b0, 1'b0, "ss_run");
    for (int c = 0; c < 3; c++) begin
      drive(ADD, 1'b0, 1'b0, 1'b0);
      #1;
      check("ss_rehold", obs, RESET_OUT);
      @(posedge clk);
      #1;
      model_edge(ADD, 1'b0, 1'b0);
    end
`endif

    // Randomized run against the model.
    cur_op    = ADD;
    halt_wait = 0;
    for (int i = 0; i < 400; i++) begin
      logic r, stp;
      if (m_phase == 0 && !m_halted)
        cur_op = ($urandom_range(0, 9) == 0) ? HLT : opcode_t'($urandom_range(1, 7));
      if (m_halted) halt_wait++;
      else          halt_wait = 0;
      r   = (halt_wait > 3) || ($urandom_range(0, 63) == 0);
      stp = logic'($urandom_range(0, 3) != 0);
      tick((m_phase < 3 && !m_halted) ? opcode_t'($urandom_range(0, 7)) : cur_op,
           logic'($urandom_range(0, 1)), stp, r, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
